// File: rtl/write_augmented_if.sv
// Pixel-stream input and BRAM write port of the augmenting frame writer.
// The slave side is the writer; the master side feeds pixels and observes writes.
interface write_augmented_if #(
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 11
);
  logic [PIX_W-1:0]  pixel;
  logic              pixel_valid;
  logic              pixel_ready;
  logic [ADDR_W-1:0] bram_addr;
  logic [PIX_W-1:0]  bram_data;
  logic              w_enable;

  modport slave (
    input  pixel, pixel_valid,
    output pixel_ready, bram_addr, bram_data, w_enable
  );

  modport master (
    output pixel, pixel_valid,
    input  pixel_ready, bram_addr, bram_data, w_enable
  );
endinterface

// File: rtl/write_augmented.sv
// Frame writer: takes a raster pixel stream, applies pass / invert / 3x3 Gaussian blur
// selected per frame, and writes one output pixel per image position into BRAM.
module write_augmented #(
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int PIX_W     = 8,
  parameter int ADDR_W    = 11,
  parameter int BASE_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           mode,
  write_augmented_if.slave     bus,
  output logic                 frame_done,
  output logic                 busy
);
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int FL_W  = $clog2(IMG_W + 1);
  localparam int SR_N  = 2 * IMG_W + 2;
  localparam int SUM_W = PIX_W + 4;
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [FL_W-1:0]   FL_LAST  = FL_W'(IMG_W);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [1:0]        M_INV    = 2'd1;
  localparam logic [1:0]        M_BLUR   = 2'd2;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t state, state_nxt;
  logic [1:0]        mode_q;
  logic [COL_W-1:0]  in_col, out_col;
  logic [ROW_W-1:0]  in_row, out_row;
  logic [FL_W-1:0]   flush_cnt;
  logic [ADDR_W-1:0] wr_cnt;
  logic [PIX_W-1:0]  sr [SR_N];

  logic [ADDR_W-1:0] addr_p1;
  logic [PIX_W-1:0]  data_p1;
  logic              vld_p1;
  logic              done_p1;

  logic              accept, flushing, last_in, primed, wr_go;
  logic [1:0]        eff_mode;
  logic              is_blur;
  logic [PIX_W-1:0]  new_pix, wr_data, blur_pix;
  logic [SUM_W-1:0]  edge_sum, corn_sum, blur_sum;
  logic              top, bot, lft, rgt;

  function automatic logic [SUM_W-1:0] widen(input logic [PIX_W-1:0] p);
    return {4'b0000, p};
  endfunction

  // Kernel weights total 16, so dropping the low four bits can never overflow PIX_W.
  function automatic logic [PIX_W-1:0] trunc_sum(input logic [SUM_W-1:0] s);
    return s[SUM_W-1:4];
  endfunction

  assign accept          = bus.pixel_valid & bus.pixel_ready;
  assign flushing        = (state == FLUSH);
  assign bus.pixel_ready = (state == IDLE) || (state == RUN);
  assign busy            = (state == RUN) || (state == FLUSH);
  assign eff_mode        = (state == IDLE) ? mode : mode_q;
  assign is_blur         = (eff_mode == M_BLUR);
  assign last_in         = (in_row == ROW_LAST) && (in_col == COL_LAST);
  assign primed          = (in_row != '0) && !((in_row == ROW_W'(1)) && (in_col == '0));
  assign new_pix         = flushing ? '0 : bus.pixel;
  assign wr_go           = (accept && (!is_blur || primed)) || flushing;

  // Window offsets count back from the incoming pixel (offset 0); sr[j] is offset j+1.
  always_comb begin
    top = (out_row == '0);
    bot = (out_row == ROW_LAST);
    lft = (out_col == '0);
    rgt = (out_col == COL_LAST);
    edge_sum = (lft ? '0 : widen(sr[IMG_W+1])) + (rgt ? '0 : widen(sr[IMG_W-1]))
             + (top ? '0 : widen(sr[2*IMG_W])) + (bot ? '0 : widen(sr[0]));
    corn_sum = ((top | lft) ? '0 : widen(sr[2*IMG_W+1])) + ((top | rgt) ? '0 : widen(sr[2*IMG_W-1]))
             + ((bot | lft) ? '0 : widen(sr[1]))         + ((bot | rgt) ? '0 : widen(new_pix));
    blur_sum = (widen(sr[IMG_W]) << 2) + (edge_sum << 1) + corn_sum;
    blur_pix = trunc_sum(blur_sum);
  end

  always_comb begin
    wr_data = bus.pixel;
    if (is_blur)
      wr_data = blur_pix;
    else if (eff_mode == M_INV)
      wr_data = ~bus.pixel;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (accept && last_in) state_nxt = (mode_q == M_BLUR) ? FLUSH : DONE;
      FLUSH:   if (flush_cnt == FL_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mode_q    <= '0;
      in_col    <= '0;
      in_row    <= '0;
      out_col   <= '0;
      out_row   <= '0;
      flush_cnt <= '0;
      wr_cnt    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && accept)
        mode_q <= mode;
      if (accept) begin
        if (in_col == COL_LAST) begin
          in_col <= '0;
          in_row <= (in_row == ROW_LAST) ? '0 : in_row + 1'b1;
        end else begin
          in_col <= in_col + 1'b1;
        end
      end
      flush_cnt <= flushing ? flush_cnt + 1'b1 : '0;
      if (wr_go) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (out_col == COL_LAST) begin
          out_col <= '0;
          out_row <= (out_row == ROW_LAST) ? '0 : out_row + 1'b1;
        end else begin
          out_col <= out_col + 1'b1;
        end
      end else if (state == DONE) begin
        wr_cnt <= '0;
      end
    end
  end

  // Stage p1: registered BRAM write port, one cycle after the accept/flush cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_p1 <= BASE;
      data_p1 <= '0;
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
      for (int j = 0; j < SR_N; j++) sr[j] <= '0;
    end else begin
      vld_p1  <= wr_go;
      done_p1 <= (state == DONE);
      if (wr_go) begin
        addr_p1 <= BASE + wr_cnt;
        data_p1 <= wr_data;
      end else if (state == DONE) begin
        addr_p1 <= BASE;
      end
      if (accept || flushing) begin
        sr[0] <= new_pix;
        for (int j = 1; j < SR_N; j++) sr[j] <= sr[j-1];
      end
    end
  end

  assign bus.bram_addr = addr_p1;
  assign bus.bram_data = data_p1;
  assign bus.w_enable  = vld_p1;
  assign frame_done    = done_p1;
endmodule

// File: tb/tb_write_augmented.sv
// Scoreboard bench for write_augmented: a 4x4 instance at base 0x100 for the mode tests
// and a default 28x28 instance for the full-size pass frame.
module tb_write_augmented;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [1:0] mode2 = 2'd0;
  logic       frame_done, busy, frame_done2, busy2;

  write_augmented_if #(.PIX_W(8), .ADDR_W(11)) bus ();
  write_augmented_if #(.PIX_W(8), .ADDR_W(11)) bus2 ();

  always #5 clk = ~clk;

  write_augmented #(.IMG_W(4), .IMG_H(4), .PIX_W(8), .ADDR_W(11), .BASE_ADDR(256)) dut (
    .clk(clk), .reset(reset), .mode(mode), .bus(bus), .frame_done(frame_done), .busy(busy)
  );

  write_augmented big (
    .clk(clk), .reset(reset), .mode(mode2), .bus(bus2), .frame_done(frame_done2), .busy(busy2)
  );

  typedef struct packed {
    logic [10:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0, checks = 0;
  int   done_count = 0, flush_wr = 0;
  int   wr2_count = 0, done2_count = 0;
  logic [10:0] last_addr2 = '0;
  logic prev_we = 1'b0, prev_rdy = 1'b1;

  logic [7:0] inv_vec [16] = '{8'h00, 8'h01, 8'hFF, 8'h80, 8'h7F, 8'h55, 8'hAA, 8'h0F,
                               8'hF0, 8'h10, 8'h20, 8'h40, 8'hC3, 8'h3C, 8'hE7, 8'h18};
  logic [7:0] flat_exp [16] = '{8'h09, 8'h0C, 8'h0C, 8'h09, 8'h0C, 8'h10, 8'h10, 8'h0C,
                                8'h0C, 8'h10, 8'h10, 8'h0C, 8'h09, 8'h0C, 8'h0C, 8'h09};
  logic [7:0] imp_exp [16]  = '{8'h0F, 8'h1E, 8'h0F, 8'h00, 8'h1E, 8'h3C, 8'h1E, 8'h00,
                                8'h0F, 8'h1E, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endfunction

  // Scoreboard monitor for the 4x4 instance.
  always @(negedge clk) begin
    if (!reset) begin
      prev_we  = 1'b0;
      prev_rdy = 1'b1;
    end else begin
      if (bus.w_enable) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with no write pending", bus.bram_addr, bus.bram_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("write_addr", 32'(bus.bram_addr), 32'(e.addr));
          chk("write_data", 32'(bus.bram_data), 32'(e.data));
        end
        if (!prev_rdy) flush_wr++;
      end
      if (frame_done) begin
        done_count++;
        chk("done_after_last_write", 32'(prev_we), 32'd1);
        chk("done_all_written", 32'(exp_q.size()), 32'd0);
      end
      prev_we  = bus.w_enable;
      prev_rdy = bus.pixel_ready;
    end
  end

  // Monitor for the 28x28 instance: write k goes to address k with data k mod 256.
  always @(negedge clk) begin
    if (reset) begin
      if (bus2.w_enable) begin
        chk("big_addr", 32'(bus2.bram_addr), 32'(wr2_count));
        chk("big_data", 32'(bus2.bram_data), 32'(wr2_count & 255));
        last_addr2 = bus2.bram_addr;
        wr2_count++;
      end
      if (frame_done2) done2_count++;
    end
  end

  task automatic send(input logic [7:0] p);
    int g;
    g = 0;
    bus.pixel = p;
    bus.pixel_valid = 1'b1;
    while (!bus.pixel_ready && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 50) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.pixel_valid = 1'b0;
  endtask

  task automatic send2(input logic [7:0] p);
    bus2.pixel = p;
    bus2.pixel_valid = 1'b1;
    @(posedge clk); #1;
    bus2.pixel_valid = 1'b0;
  endtask

  task automatic bubble(input int n);
    bus.pixel_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while (!frame_done && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    chk("frame_done_seen", 32'(frame_done), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic push_frame(input logic [7:0] d [16]);
    for (int k = 0; k < 16; k++) exp_q.push_back(exp_t'{11'(256 + k), d[k]});
  endtask

  initial begin
    logic [7:0] v [16];
    int d0, g;
    bus.pixel = '0;  bus.pixel_valid = 1'b0;
    bus2.pixel = '0; bus2.pixel_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.pixel_ready), 32'd1);
    chk("rst_we", 32'(bus.w_enable), 32'd0);
    chk("rst_addr", 32'(bus.bram_addr), 32'h100);
    chk("rst_data", 32'(bus.bram_data), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // 1: pass, 0x01..0x10
    mode = 2'd0;
    for (int k = 0; k < 16; k++) v[k] = 8'(k + 1);
    push_frame(v);
    flush_wr = 0;
    for (int k = 0; k < 16; k++) begin
      send(8'(k + 1));
      chk("pass_write_latency", 32'(bus.w_enable), 32'd1);
      if (k == 0) chk("busy_in_run", 32'(busy), 32'd1);
    end
    wait_done();
    chk("pass_no_flush_writes", 32'(flush_wr), 32'd0);
    chk("addr_back_to_base", 32'(bus.bram_addr), 32'h100);
    chk("idle_not_busy", 32'(busy), 32'd0);

    // 2: invert, mode flipped to blur mid-frame
    mode = 2'd1;
    for (int k = 0; k < 16; k++) v[k] = ~inv_vec[k];
    push_frame(v);
    for (int k = 0; k < 16; k++) begin
      send(inv_vec[k]);
      if (k == 5) mode = 2'd2;
    end
    wait_done();

    // 3: blur of a flat 0x10 frame
    mode = 2'd2;
    push_frame(flat_exp);
    flush_wr = 0;
    for (int k = 0; k < 16; k++) begin
      send(8'h10);
      if (k == 4) chk("blur_no_write_before_6th", 32'(bus.w_enable), 32'd0);
      if (k == 5) chk("blur_first_write_6th", 32'(bus.w_enable), 32'd1);
    end
    chk("flush_not_ready", 32'(bus.pixel_ready), 32'd0);
    chk("flush_busy", 32'(busy), 32'd1);
    wait_done();
    chk("blur_flush_writes", 32'(flush_wr), 32'd5);

    // 4: blur of an impulse at (1,1) with 3-cycle bubbles
    push_frame(imp_exp);
    flush_wr = 0;
    for (int k = 0; k < 16; k++) begin
      send((k == 5) ? 8'hF0 : 8'h00);
      if (k % 3 == 2) bubble(3);
    end
    wait_done();
    chk("impulse_flush_writes", 32'(flush_wr), 32'd5);

    // 5: reset during row 2, then a clean frame
    mode = 2'd0;
    for (int k = 0; k < 16; k++) v[k] = 8'(k + 8'h40);
    push_frame(v);
    for (int k = 0; k < 10; k++) send(8'(k + 8'h40));
    reset = 1'b0;
    #1;
    chk("abort_we", 32'(bus.w_enable), 32'd0);
    chk("abort_addr", 32'(bus.bram_addr), 32'h100);
    chk("abort_data", 32'(bus.bram_data), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(bus.pixel_ready), 32'd1);
    exp_q.delete();
    d0 = done_count;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_no_frame_done", 32'(done_count), 32'(d0));
    push_frame(v);
    for (int k = 0; k < 16; k++) send(v[k]);
    wait_done();

    // 6: default 28x28 instance, pass
    mode2 = 2'd0;
    wr2_count = 0;
    done2_count = 0;
    for (int k = 0; k < 784; k++) send2(8'(k));
    g = 0;
    while (!frame_done2 && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    chk("big_frame_done_seen", 32'(frame_done2), 32'd1);
    @(posedge clk); #1;
    chk("big_write_count", 32'(wr2_count), 32'd784);
    chk("big_last_addr", 32'(last_addr2), 32'h30F);
    chk("big_done_count", 32'(done2_count), 32'd1);
    chk("total_frames_done", 32'(done_count), 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
